// File: rtl/sga_direction_sensor.sv
// Direction sensor responder for the Snake Game control unit.
// A medir pulse starts one measurement. The left ultrasonic sensor is
// triggered and timed first, then the right one.
// Each echo width is classified as near or far, and the two results are
// returned as {dir, esq} together with a one-cycle fim_inter pulse.
module sga_direction_sensor #(
    parameter int TRIGGER_CYCLES   = 500,
    parameter int THRESHOLD_CYCLES = 29000,
    parameter int TIMEOUT_CYCLES   = 1500000
) (
    input  logic       clock,
    input  logic       restart_n,
    input  logic       medir,
    input  logic       reset_interface,
    input  logic       echo_esq,
    input  logic       echo_dir,
    output logic       trigger_esq,
    output logic       trigger_dir,
    output logic       fim_inter,
    output logic [1:0] interface_direction,
    output logic       timeout,
    output logic [3:0] db_state
);

    localparam int TRIG_W  = $clog2(TRIGGER_CYCLES + 1);
    localparam int WIDTH_W = $clog2(THRESHOLD_CYCLES + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        TRIG_ESQ = 4'd1,
        WAIT_ESQ = 4'd2,
        MEDE_ESQ = 4'd3,
        TRIG_DIR = 4'd4,
        WAIT_DIR = 4'd5,
        MEDE_DIR = 4'd6,
        FIM      = 4'd7
    } state_t;

    state_t             state_q;
    logic [TRIG_W-1:0]  trigCnt_q;
    logic [WIDTH_W-1:0] widthCnt_q;
    logic [TO_W-1:0]    toCnt_q;
    logic               trigEsq_q;
    logic               trigDir_q;
    logic               fim_q;
    logic [1:0]         direction_q;
    logic               timeout_q;
    logic               nearEsq_q;
    logic               toFlag_q;

    logic echoEsqMeta_q, echoEsqSync_q, echoEsqPrev_q;
    logic echoDirMeta_q, echoDirSync_q, echoDirPrev_q;

    logic isDirSide;
    logic curSync;
    logic curRise;
    logic trigDone;
    logic toExpired;
    logic widthNear;
    logic sensorDone;
    logic sensorNear;
    logic sensorTimedOut;

    // Bring both echo pins into the clock domain and keep one extra stage for edge detection
    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            echoEsqMeta_q <= 1'b0;
            echoEsqSync_q <= 1'b0;
            echoEsqPrev_q <= 1'b0;
            echoDirMeta_q <= 1'b0;
            echoDirSync_q <= 1'b0;
            echoDirPrev_q <= 1'b0;
        end else begin
            echoEsqMeta_q <= echo_esq;
            echoEsqSync_q <= echoEsqMeta_q;
            echoEsqPrev_q <= echoEsqSync_q;
            echoDirMeta_q <= echo_dir;
            echoDirSync_q <= echoDirMeta_q;
            echoDirPrev_q <= echoDirSync_q;
        end
    end

    // Select the sensor being measured and decide whether its measurement ends this cycle
    always_comb begin
        isDirSide      = (state_q == TRIG_DIR) || (state_q == WAIT_DIR) || (state_q == MEDE_DIR);
        curSync        = isDirSide ? echoDirSync_q : echoEsqSync_q;
        // A rise needs a low sample first, so an echo already high on entry to WAIT is ignored
        curRise        = curSync && !(isDirSide ? echoDirPrev_q : echoEsqPrev_q);
        trigDone       = (trigCnt_q == TRIG_W'(TRIGGER_CYCLES - 1));
        toExpired      = (toCnt_q == TO_W'(TIMEOUT_CYCLES - 1));
        // The rising-edge cycle already saw the echo high, so the width is the count plus one
        widthNear      = (widthCnt_q < WIDTH_W'(THRESHOLD_CYCLES - 1));
        sensorDone     = 1'b0;
        sensorNear     = 1'b0;
        sensorTimedOut = 1'b0;
        if ((state_q == WAIT_ESQ) || (state_q == WAIT_DIR)) begin
            if (toExpired) begin
                sensorDone     = 1'b1;
                sensorTimedOut = 1'b1;
            end
        end else if ((state_q == MEDE_ESQ) || (state_q == MEDE_DIR)) begin
            if (toExpired) begin
                sensorDone     = 1'b1;
                sensorTimedOut = 1'b1;
            end else if (!curSync) begin
                sensorDone = 1'b1;
                sensorNear = widthNear;
            end
        end
    end

    // Measurement sequencer with registered triggers, completion pulse and results
    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            state_q     <= IDLE;
            trigCnt_q   <= '0;
            widthCnt_q  <= '0;
            toCnt_q     <= '0;
            trigEsq_q   <= 1'b0;
            trigDir_q   <= 1'b0;
            fim_q       <= 1'b0;
            direction_q <= 2'b00;
            timeout_q   <= 1'b0;
            nearEsq_q   <= 1'b0;
            toFlag_q    <= 1'b0;
        end else if (reset_interface) begin
            state_q     <= IDLE;
            trigCnt_q   <= '0;
            widthCnt_q  <= '0;
            toCnt_q     <= '0;
            trigEsq_q   <= 1'b0;
            trigDir_q   <= 1'b0;
            fim_q       <= 1'b0;
            direction_q <= 2'b00;
            timeout_q   <= 1'b0;
            nearEsq_q   <= 1'b0;
            toFlag_q    <= 1'b0;
        end else begin
            fim_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (medir) begin
                        state_q   <= TRIG_ESQ;
                        trigEsq_q <= 1'b1;
                        trigCnt_q <= '0;
                        nearEsq_q <= 1'b0;
                        toFlag_q  <= 1'b0;
                    end
                end
                TRIG_ESQ, TRIG_DIR: begin
                    if (trigDone) begin
                        trigEsq_q <= 1'b0;
                        trigDir_q <= 1'b0;
                        toCnt_q   <= '0;
                        state_q   <= isDirSide ? WAIT_DIR : WAIT_ESQ;
                    end else begin
                        trigCnt_q <= trigCnt_q + TRIG_W'(1);
                    end
                end
                WAIT_ESQ, WAIT_DIR, MEDE_ESQ, MEDE_DIR: begin
                    if (sensorDone) begin
                        if (isDirSide) begin
                            state_q     <= FIM;
                            fim_q       <= 1'b1;
                            direction_q <= {sensorNear, nearEsq_q};
                            timeout_q   <= toFlag_q | sensorTimedOut;
                        end else begin
                            nearEsq_q <= sensorNear;
                            toFlag_q  <= toFlag_q | sensorTimedOut;
                            state_q   <= TRIG_DIR;
                            trigDir_q <= 1'b1;
                            trigCnt_q <= '0;
                        end
                    end else begin
                        if (toCnt_q != '1) begin
                            toCnt_q <= toCnt_q + TO_W'(1);
                        end
                        if ((state_q == WAIT_ESQ) || (state_q == WAIT_DIR)) begin
                            if (curRise) begin
                                widthCnt_q <= '0;
                                state_q    <= isDirSide ? MEDE_DIR : MEDE_ESQ;
                            end
                        end else if (widthCnt_q != '1) begin
                            widthCnt_q <= widthCnt_q + WIDTH_W'(1);
                        end
                    end
                end
                FIM: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign trigger_esq         = trigEsq_q;
    assign trigger_dir         = trigDir_q;
    assign fim_inter           = fim_q;
    assign interface_direction = direction_q;
    assign timeout             = timeout_q;
    assign db_state            = state_q;

endmodule

// File: doc/sga_direction_sensor.md
# sga_direction_sensor

Responder side of the direction-measurement handshake driven by the Snake Game control unit. On a `medir` pulse it triggers two ultrasonic sensors one after the other (left, then right) and times each echo. It classifies each hand as near or far, then returns `interface_direction = {dir, esq}` with a one-cycle `fim_inter`. It sits between the sensor pins and the control unit; the datapath samples `interface_direction` when the control unit asserts `enable_interface`.

## Interface
- `TRIGGER_CYCLES`, default 500: trigger pulse width in clocks (10 µs at 50 MHz).
- `THRESHOLD_CYCLES`, default 29000: echo width below which a sensor reads "near" (≈10 cm at 50 MHz).
- `TIMEOUT_CYCLES`, default 1500000: per-sensor limit from end of trigger (30 ms at 50 MHz).
- `clock` in 1: system clock, rising edge.
- `restart_n` in 1: asynchronous, active-low reset.
- `medir` in 1: start request, single-cycle pulse from the control unit.
- `reset_interface` in 1: synchronous clear; returns the block to IDLE.
- `echo_esq` in 1: left sensor echo, asynchronous.
- `echo_dir` in 1: right sensor echo, asynchronous.
- `trigger_esq` out 1: left sensor trigger.
- `trigger_dir` out 1: right sensor trigger.
- `fim_inter` out 1: measurement complete, one-cycle pulse.
- `interface_direction` out 2: {dir_near, esq_near}, registered.
- `timeout` out 1: set if either sensor timed out in the last measurement.
- `db_state` out 4: current state encoding, for debug.

## Operation
- Both echo inputs pass through 2-FF synchronizers. All echo logic uses the synchronized signals.
- States and their `db_state` codes:
  - IDLE (0): `medir` → TRIG_ESQ.
  - TRIG_ESQ (1): `trigger_esq` = 1 for exactly TRIGGER_CYCLES cycles → WAIT_ESQ.
  - WAIT_ESQ (2): waits for a synchronized rising edge of `echo_esq` → MEDE_ESQ.
  - MEDE_ESQ (3): counts cycles while the echo is high. Falling edge → TRIG_DIR.
  - TRIG_DIR (4), WAIT_DIR (5), MEDE_DIR (6): identical sequence on the right sensor; MEDE_DIR exits → FIM.
  - FIM (7): `fim_inter` = 1 → IDLE.
- Per sensor:
  - The timeout counter clears on entry to WAIT_x and increments every cycle in WAIT_x and MEDE_x.
  - The width counter clears on entry to MEDE_x.
  - Near = the echo fell with width W satisfying 1 ≤ W < THRESHOLD_CYCLES.
  - W ≥ THRESHOLD_CYCLES → far.
- Timeout: when the timeout counter reaches TIMEOUT_CYCLES−1 in WAIT_x or MEDE_x, the sensor reads far, the sticky timeout flag for the current measurement is set, and the FSM advances as on a falling edge.
- Stale echo: an echo already high on entry to WAIT_x is not a rising edge. The FSM waits for low-then-high, or times out.
- Counters saturate and never wrap. Widths are ceil(log2(max parameter+1)) bits.
- In FIM, the two near bits load into `interface_direction` (bit1 = right, bit0 = left) and the timeout flag loads into `timeout`. Both hold until the next FIM or a reset.
- `medir` is ignored in every state except IDLE.
- `reset_interface` has priority over `medir` and over all transitions. It forces IDLE, clears counters and triggers, and sets `interface_direction` = 00 and `timeout` = 0.

## Timing
- Reset values (`restart_n` low, or `reset_interface` at the next edge): state IDLE, all outputs 0, `db_state` = 0.
- `medir` sampled at edge k → `trigger_esq` high from k+1 through k+TRIGGER_CYCLES.
- Echo edges appear in synchronized form 2 cycles after the pin.
- `fim_inter` is high for exactly one cycle. `interface_direction` and `timeout` are valid in that same cycle and stay stable afterwards.
- `trigger_dir` rises the cycle after the left measurement ends. The two triggers are never high together.
- Worst-case latency from `medir` to `fim_inter`: 2·(TRIGGER_CYCLES + TIMEOUT_CYCLES) + small constant, within 5 clocks.

## Test plan
All scenarios use TRIGGER_CYCLES=4, THRESHOLD_CYCLES=20, TIMEOUT_CYCLES=100.
- Reset and clear:
  - `restart_n` low mid-MEDE_DIR → all outputs 0 and `db_state` = 0 immediately; the next `medir` starts a fresh TRIG_ESQ.
  - `reset_interface` during TRIG_DIR → `trigger_dir` drops, IDLE, `interface_direction` = 00.
- Left near / right far: `medir`, left echo 10 cycles, right echo 40 cycles → one `fim_inter`, `interface_direction` = 01, `timeout` = 0, `trigger_esq` exactly 4 cycles.
- Boundary widths: left echo 19 cycles, right echo 20 cycles → 01. Left echo 20 cycles, right echo 5 cycles → 10.
- Timeout: right echo never rises → `fim_inter` about 100 cycles after the right trigger ends, `interface_direction` = 0x with the left bit correct, `timeout` = 1. Left echo stuck high from before `medir` → left far, `timeout` = 1.
- Ignored request: extra `medir` pulses during WAIT_ESQ → no restart, exactly one `fim_inter`. Both echoes 5 cycles → 11, held until the next FIM.
